// File: rtl/board_io_pkg.sv
// Shared definitions for the board I/O controller: 7-segment decoding,
// counter sizing and the CPU clock-enable mode.
package board_io_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {
      MODE_STEP = 1'b0,
      MODE_RUN  = 1'b1
   } cpu_mode_e;

   // Bits needed to hold 0..value-1, never less than one bit.
   function automatic int cntWidth(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

   // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// One push button: two-flop synchroniser, sample-counting debouncer and a
// one-cycle pulse on each accepted press.
module btn_debounce
   import board_io_pkg::*;
#(
   parameter int DB_CNT = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   input  logic tick_i,
   output logic db_o,
   output logic rise_o
);

   localparam int CNT_W = cntWidth(DB_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

   logic             syncMeta_q;
   logic             sync_q;
   logic             db_q;
   logic             rise_q;
   logic [CNT_W-1:0] cnt_q;

   // A new level is accepted only after DB_CNT consecutive samples disagree with it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         syncMeta_q <= 1'b0;
         sync_q     <= 1'b0;
         db_q       <= 1'b0;
         rise_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         syncMeta_q <= btn_i;
         sync_q     <= syncMeta_q;
         rise_q     <= 1'b0;
         if (tick_i) begin
            if (sync_q == db_q) begin
               cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
               db_q   <= sync_q;
               rise_q <= sync_q;
               cnt_q  <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign db_o   = db_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced buttons, CPU clock-enable (run/step),
// paged hex 7-segment scanner and paged LED mux, all on one clock.
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int NUM_BTN    = 4,
   parameter int NUM_DIGITS = 4,
   parameter int DATA_W     = 32,
   parameter int LED_W      = 16,
   parameter int SCAN_DIV   = 100_000,
   parameter int DB_DIV     = 1_000_000,
   parameter int DB_CNT     = 2,
   parameter int RUN_DIV    = 1_000_000,
   parameter int STEP_BTN   = 0,
   parameter int PAGE_BTN   = 1,
   parameter int LED_BTN    = 2
) (
   input  logic                                             CLK,
   input  logic                                             RST_N,
   input  logic [NUM_BTN-1:0]                               btn_i,
   input  logic                                             run_mode_i,
   input  logic [DATA_W-1:0]                                disp_data_i,
   input  logic [2*LED_W-1:0]                               led_data_i,
   output logic [NUM_BTN-1:0]                               btn_db_o,
   output logic [NUM_BTN-1:0]                               btn_rise_o,
   output logic                                             cpu_en_o,
   output logic [cntWidth(DATA_W/(4*NUM_DIGITS))-1:0]       page_o,
   output logic [6:0]                                       seg_o,
   output logic [NUM_DIGITS-1:0]                            an_o,
   output logic [LED_W-1:0]                                 led_o
);

   localparam int NUM_PAGES = DATA_W / (4 * NUM_DIGITS);
   localparam int PAGE_W    = cntWidth(NUM_PAGES);
   localparam int IDX_W     = cntWidth(NUM_DIGITS);
   localparam int NUM_NIB   = DATA_W / 4;
   localparam int NIB_W     = cntWidth(NUM_NIB);
   localparam int SCAN_W    = cntWidth(SCAN_DIV);
   localparam int DB_W      = cntWidth(DB_DIV);
   localparam int RUN_W     = cntWidth(RUN_DIV);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

   logic [SCAN_W-1:0]     scanCnt_q;
   logic [DB_W-1:0]       dbCnt_q;
   logic [RUN_W-1:0]      runCnt_q;
   logic                  scanTick;
   logic                  dbTick;
   logic                  runTick;
   cpu_mode_e             mode;

   logic [IDX_W-1:0]      idx_q,  idx_d;
   logic [PAGE_W-1:0]     page_q, page_d;
   logic [NUM_DIGITS-1:0] an_q;
   logic [6:0]            seg_q;
   logic                  cpuEn_q;
   logic [LED_W-1:0]      led_q;

   logic [3:0]            nibbles [NUM_NIB];
   logic [NIB_W-1:0]      nibSel;

   assign mode     = cpu_mode_e'(run_mode_i);
   assign scanTick = (scanCnt_q == SCAN_W'(SCAN_DIV - 1));
   assign dbTick   = (dbCnt_q   == DB_W'(DB_DIV - 1));
   assign runTick  = (runCnt_q  == RUN_W'(RUN_DIV - 1));

   // The run prescaler is parked at zero in step mode so run pulses start a full period after entry.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         scanCnt_q <= '0;
         dbCnt_q   <= '0;
         runCnt_q  <= '0;
      end else begin
         scanCnt_q <= scanTick ? '0 : scanCnt_q + 1'b1;
         dbCnt_q   <= dbTick   ? '0 : dbCnt_q + 1'b1;
         if (mode == MODE_STEP || runTick) begin
            runCnt_q <= '0;
         end else begin
            runCnt_q <= runCnt_q + 1'b1;
         end
      end
   end

   for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
      btn_debounce #(
         .DB_CNT (DB_CNT)
      ) u_debounce (
         .clk_i  (CLK),
         .rst_ni (RST_N),
         .btn_i  (btn_i[b]),
         .tick_i (dbTick),
         .db_o   (btn_db_o[b]),
         .rise_o (btn_rise_o[b])
      );
   end

   for (genvar n = 0; n < NUM_NIB; n++) begin : g_nib
      assign nibbles[n] = disp_data_i[4*n +: 4];
   end

   assign nibSel = NIB_W'(int'(page_q) * NUM_DIGITS + int'(idx_q));

   always_comb begin
      idx_d  = idx_q;
      page_d = page_q;
      if (scanTick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (btn_rise_o[PAGE_BTN]) begin
         page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
      end
   end

   // Display outputs follow the digit index by one cycle so anode and segments always switch together.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idx_q   <= '0;
         page_q  <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         cpuEn_q <= 1'b0;
         led_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         page_q  <= page_d;
         an_q    <= ~(NUM_DIGITS'(1) << idx_q);
         seg_q   <= hex7(nibbles[nibSel]);
         cpuEn_q <= (mode == MODE_RUN) ? runTick : btn_rise_o[STEP_BTN];
         led_q   <= btn_db_o[LED_BTN] ? led_data_i[2*LED_W-1:LED_W] : led_data_i[LED_W-1:0];
      end
   end

   assign page_o   = page_q;
   assign an_o     = an_q;
   assign seg_o    = seg_q;
   assign cpu_en_o = cpuEn_q;
   assign led_o    = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: cycle-level reference model plus
// directed sequences for reset, debounce, display paging, CPU enable and LEDs.
module tb_board_io_ctrl;

   localparam int NUM_DIGITS = 4;
   localparam int SCAN_DIV   = 2;
   localparam int DB_DIV     = 2;
   localparam int DB_CNT     = 4;
   localparam int RUN_DIV    = 5;
   localparam int NUM_PAGES  = 2;
   localparam int STEP_BTN   = 0;
   localparam int PAGE_BTN   = 1;
   localparam int LED_BTN    = 2;

   localparam logic [6:0] HEX_REF [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic        CLK         = 1'b0;
   logic        RST_N       = 1'b1;
   logic [3:0]  btn_i       = '0;
   logic        run_mode_i  = 1'b0;
   logic [31:0] disp_data_i = '0;
   logic [31:0] led_data_i  = '0;
   logic [3:0]  btn_db_o;
   logic [3:0]  btn_rise_o;
   logic        cpu_en_o;
   logic [0:0]  page_o;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic [15:0] led_o;

   int nChecks = 0;
   int nFails  = 0;

   always #5 CLK = ~CLK;

   board_io_ctrl #(
      .NUM_BTN    (4),
      .NUM_DIGITS (NUM_DIGITS),
      .DATA_W     (32),
      .LED_W      (16),
      .SCAN_DIV   (SCAN_DIV),
      .DB_DIV     (DB_DIV),
      .DB_CNT     (DB_CNT),
      .RUN_DIV    (RUN_DIV),
      .STEP_BTN   (STEP_BTN),
      .PAGE_BTN   (PAGE_BTN),
      .LED_BTN    (LED_BTN)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .btn_i       (btn_i),
      .run_mode_i  (run_mode_i),
      .disp_data_i (disp_data_i),
      .led_data_i  (led_data_i),
      .btn_db_o    (btn_db_o),
      .btn_rise_o  (btn_rise_o),
      .cpu_en_o    (cpu_en_o),
      .page_o      (page_o),
      .seg_o       (seg_o),
      .an_o        (an_o),
      .led_o       (led_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   // Reference model: edge counts since reset drive the prescalers, the
   // debouncer works on the history of synchronised samples.
   int          edgeN;
   int          mIdx;
   int          mPage;
   int          runLen;
   int          nib;
   int          diffRun [4];
   logic [3:0]  mDb, mRise, newRise, sampled, btnDly0, btnDly1, digitVal;
   logic [3:0]  expAn   = 4'hF;
   logic [6:0]  expSeg  = 7'h7F;
   logic [15:0] expLed  = '0;
   logic        expCpu  = 1'b0;
   int          expPage = 0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         edgeN   = 0;
         mIdx    = 0;
         mPage   = 0;
         runLen  = 0;
         mDb     = '0;
         mRise   = '0;
         btnDly0 = '0;
         btnDly1 = '0;
         for (int b = 0; b < 4; b++) diffRun[b] = 0;
         expAn   = 4'hF;
         expSeg  = 7'h7F;
         expLed  = '0;
         expCpu  = 1'b0;
         expPage = 0;
      end else begin
         edgeN++;
         nib      = mPage * NUM_DIGITS + mIdx;
         digitVal = disp_data_i[4*nib +: 4];
         expAn    = ~(4'b0001 << mIdx);
         expSeg   = HEX_REF[digitVal];
         expLed   = mDb[LED_BTN] ? led_data_i[31:16] : led_data_i[15:0];
         if (run_mode_i) begin
            runLen++;
            expCpu = ((runLen % RUN_DIV) == 0);
         end else begin
            runLen = 0;
            expCpu = mRise[STEP_BTN];
         end
         if (mRise[PAGE_BTN]) mPage = (mPage + 1) % NUM_PAGES;
         expPage = mPage;
         mIdx    = (edgeN / SCAN_DIV) % NUM_DIGITS;
         sampled = btnDly1;
         btnDly1 = btnDly0;
         btnDly0 = btn_i;
         newRise = '0;
         if ((edgeN % DB_DIV) == 0) begin
            for (int b = 0; b < 4; b++) begin
               if (sampled[b] != mDb[b]) begin
                  diffRun[b]++;
                  if (diffRun[b] == DB_CNT) begin
                     mDb[b]     = sampled[b];
                     newRise[b] = sampled[b];
                     diffRun[b] = 0;
                  end
               end else begin
                  diffRun[b] = 0;
               end
            end
         end
         mRise = newRise;
      end
   end

   always @(negedge CLK) begin
      checkOutput("model an_o",       32'(an_o),       32'(expAn));
      checkOutput("model seg_o",      32'(seg_o),      32'(expSeg));
      checkOutput("model led_o",      32'(led_o),      32'(expLed));
      checkOutput("model cpu_en_o",   32'(cpu_en_o),   32'(expCpu));
      checkOutput("model btn_db_o",   32'(btn_db_o),   32'(mDb));
      checkOutput("model btn_rise_o", 32'(btn_rise_o), 32'(mRise));
      checkOutput("model page_o",     32'(page_o),     32'(expPage));
   end

   int cpuPulses = 0, cpuRun = 0, cpuMaxRun = 0;
   int risePulses = 0, riseRun = 0, riseMaxRun = 0;

   always @(negedge CLK) begin
      if (cpu_en_o) begin
         cpuRun++;
         if (cpuRun == 1) cpuPulses++;
         if (cpuRun > cpuMaxRun) cpuMaxRun = cpuRun;
      end else begin
         cpuRun = 0;
      end
      if (btn_rise_o[0]) begin
         riseRun++;
         if (riseRun == 1) risePulses++;
         if (riseRun > riseMaxRun) riseMaxRun = riseRun;
      end else begin
         riseRun = 0;
      end
   end

   task automatic waitForAn(input logic [3:0] target, input string name);
      int n = 0;
      while (an_o !== target && n < 20) begin
         waitCycles(1);
         n++;
      end
      checkOutput(name, 32'(an_o), 32'(target));
   endtask

   task automatic waitForDb(input int b, input logic level, input string name);
      int n = 0;
      while (btn_db_o[b] !== level && n < 40) begin
         waitCycles(1);
         n++;
      end
      checkOutput(name, 32'(btn_db_o[b]), 32'(level));
   endtask

   task automatic pressButton(input int b);
      int n = 0;
      btn_i[b] = 1'b1;
      while (btn_rise_o[b] !== 1'b1 && n < 40) begin
         waitCycles(1);
         n++;
      end
      checkOutput($sformatf("rise btn%0d", b), 32'(btn_rise_o[b]), 32'd1);
      waitCycles(2);
      btn_i[b] = 1'b0;
      waitForDb(b, 1'b0, $sformatf("release btn%0d", b));
      waitCycles(2);
   endtask

   typedef struct {
      logic [31:0] disp;
      logic [31:0] led;
      logic [6:0]  seg0;
      logic [15:0] ledExp;
   } vec_t;

   vec_t vecs [8];

   task automatic applyStimulus(input vec_t v, input int idx);
      disp_data_i = v.disp;
      led_data_i  = v.led;
      waitCycles(1);
      waitForAn(4'hE, $sformatf("vec%0d digit0", idx));
      checkOutput($sformatf("vec%0d seg_o", idx), 32'(seg_o), 32'(v.seg0));
      checkOutput($sformatf("vec%0d led_o", idx), 32'(led_o), 32'(v.ledExp));
   endtask

   initial begin
      logic [0:0] pg;
      vecs[0] = '{32'h0000_0000, 32'h0000_FFFF, 7'h40, 16'hFFFF};
      vecs[1] = '{32'h0000_0005, 32'h1234_5678, 7'h12, 16'h5678};
      vecs[2] = '{32'h8765_4329, 32'hAAAA_5555, 7'h10, 16'h5555};
      vecs[3] = '{32'h0000_000F, 32'hFFFF_0000, 7'h0E, 16'h0000};
      vecs[4] = '{32'hFFFF_FFF7, 32'h0F0F_F0F0, 7'h78, 16'hF0F0};
      vecs[5] = '{32'h1111_111E, 32'h8000_0001, 7'h06, 16'h0001};
      vecs[6] = '{32'h0000_0003, 32'h0000_0000, 7'h30, 16'h0000};
      vecs[7] = '{32'hABCD_EF06, 32'hC3C3_3C3C, 7'h02, 16'h3C3C};

      #1 RST_N = 1'b0;
      disp_data_i = 32'h1234_ABCD;
      waitCycles(3);
      checkOutput("reset an_o",       32'(an_o),       32'hF);
      checkOutput("reset seg_o",      32'(seg_o),      32'h7F);
      checkOutput("reset led_o",      32'(led_o),      32'h0);
      checkOutput("reset cpu_en_o",   32'(cpu_en_o),   32'h0);
      checkOutput("reset btn_db_o",   32'(btn_db_o),   32'h0);
      checkOutput("reset btn_rise_o", 32'(btn_rise_o), 32'h0);
      checkOutput("reset page_o",     32'(page_o),     32'h0);
      RST_N = 1'b1;
      waitCycles(7);

      #2 RST_N = 1'b0;
      #1 checkOutput("async reset an_o", 32'(an_o), 32'hF);
      checkOutput("async reset seg_o", 32'(seg_o), 32'h7F);
      waitCycles(2);
      RST_N = 1'b1;
      waitCycles(1);
      checkOutput("restart an_o digit0", 32'(an_o), 32'hE);
      checkOutput("restart seg_o D", 32'(seg_o), 32'h21);

      waitForAn(4'hD, "scan digit1");
      checkOutput("seg digit1 C", 32'(seg_o), 32'h46);
      waitForAn(4'hB, "scan digit2");
      checkOutput("seg digit2 b", 32'(seg_o), 32'h03);
      waitForAn(4'h7, "scan digit3");
      checkOutput("seg digit3 A", 32'(seg_o), 32'h08);
      pressButton(PAGE_BTN);
      checkOutput("page after 1st press", 32'(page_o), 32'd1);
      waitCycles(1);
      waitForAn(4'hE, "page1 digit0");
      checkOutput("page1 seg digit0 4", 32'(seg_o), 32'h19);
      pressButton(PAGE_BTN);
      checkOutput("page after 2nd press", 32'(page_o), 32'd0);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

      risePulses = 0;
      riseMaxRun = 0;
      for (int i = 0; i < 10; i++) begin
         btn_i[0] = ~btn_i[0];
         waitCycles(3);
      end
      btn_i[0] = 1'b1;
      checkOutput("no rise during bounce", 32'(risePulses), 32'd0);
      waitForDb(0, 1'b1, "db after bounce");
      waitCycles(5);
      checkOutput("single rise after bounce", 32'(risePulses), 32'd1);
      checkOutput("rise width", 32'(riseMaxRun), 32'd1);
      btn_i[0] = 1'b0;
      waitForDb(0, 1'b0, "db release after bounce");
      waitCycles(3);

      cpuPulses = 0;
      cpuMaxRun = 0;
      for (int i = 0; i < 3; i++) pressButton(STEP_BTN);
      waitCycles(3);
      checkOutput("step pulses", 32'(cpuPulses), 32'd3);
      checkOutput("step pulse width", 32'(cpuMaxRun), 32'd1);
      cpuPulses = 0;
      run_mode_i = 1'b1;
      waitCycles(50);
      checkOutput("run pulses in 50 clk", 32'(cpuPulses), 32'd10);
      checkOutput("run pulse width", 32'(cpuMaxRun), 32'd1);
      run_mode_i = 1'b0;
      cpuPulses = 0;
      waitCycles(30);
      checkOutput("no pulses after run off", 32'(cpuPulses), 32'd0);

      led_data_i = 32'hDEAD_BEEF;
      waitCycles(2);
      checkOutput("led low half", 32'(led_o), 32'hBEEF);
      btn_i[LED_BTN] = 1'b1;
      waitForDb(LED_BTN, 1'b1, "led btn db");
      waitCycles(1);
      checkOutput("led high half", 32'(led_o), 32'hDEAD);
      btn_i[LED_BTN] = 1'b0;
      waitForDb(LED_BTN, 1'b0, "led btn release");
      waitCycles(1);
      checkOutput("led low half again", 32'(led_o), 32'hBEEF);

      pg = page_o;
      btn_i[STEP_BTN] = 1'b1;
      btn_i[PAGE_BTN] = 1'b1;
      begin
         int n = 0;
         while (btn_rise_o[STEP_BTN] !== 1'b1 && n < 40) begin
            waitCycles(1);
            n++;
         end
      end
      checkOutput("dual rise", 32'(btn_rise_o), 32'h3);
      waitCycles(1);
      checkOutput("dual cpu_en", 32'(cpu_en_o), 32'd1);
      checkOutput("dual page", 32'(page_o), 32'((pg + 1'b1) % 2));
      btn_i[STEP_BTN] = 1'b0;
      btn_i[PAGE_BTN] = 1'b0;
      waitForDb(STEP_BTN, 1'b0, "dual release step");
      waitForDb(PAGE_BTN, 1'b0, "dual release page");

      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 11) == 0) btn_i[b] = ~btn_i[b];
         end
         if ($urandom_range(0, 63) == 0) run_mode_i = ~run_mode_i;
         if ($urandom_range(0, 99) == 0) disp_data_i = $urandom;
         if ($urandom_range(0, 99) == 0) led_data_i = $urandom;
         if (i == 700) begin
            #2 RST_N = 1'b0;
            waitCycles(2);
            RST_N = 1'b1;
         end
         waitCycles(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
